// File: rtl/jtag_ram_pkg.sv
// Shared constants for the JTAG/local RAM arbiter: default RAM geometry,
// request address width and requester indices.
package jtag_ram_pkg;
   localparam int ADDR_W_DEF = 9;
   localparam int DATA_W_DEF = 32;
   localparam int REQ_ADDR_W = 31;
   localparam int CNT_W      = 16;
   localparam int REQ_JTAG   = 0;
   localparam int REQ_LOCAL  = 1;
endpackage

// File: rtl/jtag_ram_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last.
module jtag_ram_rr2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);
   assign grant_o[0] = req_i[0] & (~req_i[1] | last_i);
   assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/jtag_ram_arbiter.sv
// Arbitrates JTAG (port 0) and local (port 1) access to a single-port block RAM.
// Optional grant statistics counters: define JTAG_RAM_ARBITER_STATS_EN.
module jtag_ram_arbiter
   import jtag_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  clk_p,
   input  logic                  RESET_N,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [REQ_ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0]     wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   output logic [DATA_W-1:0]     rdata0,
   output logic                  err0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [REQ_ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_W-1:0]     rdata1,
   output logic                  err1,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic [CNT_W-1:0]      grant_cnt0,
   output logic [CNT_W-1:0]      grant_cnt1
);
   logic [1:0]            req;
   logic [1:0]            grant;
   logic [1:0]            gnt;
   logic                  last_q, last_d;
   logic                  win_we;
   logic                  win_oor;
   logic [REQ_ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0]     win_wdata;
   logic [1:0]            rsp_vld_q;
   logic                  rsp_err_q;
   logic                  rsp_rd_q;

   assign req = {req1, req0};

   jtag_ram_rr2 u_rr2 (
      .req_i   (req),
      .last_i  (last_q),
      .grant_o (grant)
   );

   // Grants are combinational, so gate them with reset to keep them low while held.
   assign gnt  = RESET_N ? grant : 2'b00;
   assign gnt0 = gnt[REQ_JTAG];
   assign gnt1 = gnt[REQ_LOCAL];

   assign win_we    = gnt[REQ_LOCAL] ? we1    : we0;
   assign win_addr  = gnt[REQ_LOCAL] ? addr1  : addr0;
   assign win_wdata = gnt[REQ_LOCAL] ? wdata1 : wdata0;
   assign win_oor   = |win_addr[REQ_ADDR_W-1:ADDR_W];

   assign ram_en    = (|gnt) & ~win_oor;
   assign ram_we    = ram_en & win_we;
   assign ram_addr  = win_addr[ADDR_W-1:0];
   assign ram_wdata = win_wdata;

   always_comb begin
      last_d = last_q;
      if (|gnt) last_d = gnt[REQ_LOCAL];
   end

   // last_q resets to 1 so that port 0 wins the first tie.
   always_ff @(posedge clk_p or negedge RESET_N) begin
      if (!RESET_N) begin
         last_q    <= 1'b1;
         rsp_vld_q <= 2'b00;
         rsp_err_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
      end else begin
         last_q    <= last_d;
         rsp_vld_q <= gnt;
         rsp_err_q <= (|gnt) & win_oor;
         rsp_rd_q  <= ram_en & ~win_we;
      end
   end

   assign rvalid0 = rsp_vld_q[REQ_JTAG];
   assign rvalid1 = rsp_vld_q[REQ_LOCAL];
   assign rdata0  = (rsp_vld_q[REQ_JTAG]  & rsp_rd_q) ? ram_rdata : '0;
   assign rdata1  = (rsp_vld_q[REQ_LOCAL] & rsp_rd_q) ? ram_rdata : '0;
   assign err0    = rsp_vld_q[REQ_JTAG]  & rsp_err_q;
   assign err1    = rsp_vld_q[REQ_LOCAL] & rsp_err_q;

`ifdef JTAG_RAM_ARBITER_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk_p or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt[REQ_JTAG]  && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + 1'b1;
         if (gnt[REQ_LOCAL] && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_jtag_ram_arbiter.sv
// Scoreboard bench for jtag_ram_arbiter with a behavioural 512x32 RAM.
module tb_jtag_ram_arbiter;
   logic        clk_p = 1'b0;
   logic        RESET_N = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [30:0] addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        ram_en, ram_we;
   logic [8:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [15:0] grant_cnt0, grant_cnt1;

   typedef struct {
      int          port;
      int          due;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem [512];
   logic [31:0] exp_mem [512];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   jtag_ram_arbiter dut (
      .clk_p(clk_p), .RESET_N(RESET_N),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   always #5 clk_p = ~clk_p;

   always @(posedge clk_p) begin
      cyc = cyc + 1;
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we) mem[ram_addr] = ram_wdata;
      end
   end

   // Response monitor: every rvalid must match the oldest expectation, at its due cycle.
   always @(negedge clk_p) begin
      if (RESET_N) begin
         for (int p = 0; p < 2; p++) begin
            logic        rv, er;
            logic [31:0] rd;
            exp_t        e;
            rv = (p == 0) ? rvalid0 : rvalid1;
            rd = (p == 0) ? rdata0  : rdata1;
            er = (p == 0) ? err0    : err1;
            checks++;
            if (rv === 1'b1) begin
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rvalid port %0d cycle %0d: rvalid=1, required 0", p, cyc);
               end else begin
                  e = q.pop_front();
                  if (e.port != p || e.due != cyc || rd !== e.rdata || er !== e.err) begin
                     errors++;
                     $display("FAIL response port %0d cycle %0d: rdata=%h err=%b, required port %0d cycle %0d rdata=%h err=%b",
                              p, cyc, rd, er, e.port, e.due, e.rdata, e.err);
                  end
               end
            end else if (rv !== 1'b0 || rd !== 32'h0 || er !== 1'b0) begin
               errors++;
               $display("FAIL idle_port %0d cycle %0d: rvalid=%b rdata=%h err=%b, required 0/0/0", p, cyc, rv, rd, er);
            end
         end
         if (q.size() != 0 && q[0].due <= cyc) begin
            errors++;
            $display("FAIL missing_rvalid port %0d: no response at cycle %0d, required rdata=%h err=%b",
                     q[0].port, q[0].due, q[0].rdata, q[0].err);
            void'(q.pop_front());
         end
      end
   end

   task automatic drive(input int p, input logic r, input logic w, input logic [30:0] a, input logic [31:0] d);
      if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic push_exp(input int p, input logic w, input logic [30:0] a, input logic [31:0] d);
      exp_t e;
      logic oor;
      oor     = |a[30:9];
      e.port  = p;
      e.due   = cyc + 1;
      e.err   = oor;
      e.rdata = (!w && !oor) ? exp_mem[a[8:0]] : 32'h0;
      q.push_back(e);
      if (w && !oor) exp_mem[a[8:0]] = d;
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic issue(input int p, input logic w, input logic [30:0] a, input logic [31:0] d,
                        input bit expect_rsp, output int waited);
      int   wc;
      bit   got;
      logic oor;
      wc  = 0;
      got = 0;
      oor = |a[30:9];
      drive(p, 1'b1, w, a, d);
      while (!got && wc < 20) begin
         @(negedge clk_p);
         if (((p == 0) ? gnt0 : gnt1) === 1'b1) got = 1;
         else wc++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout port %0d addr %h: gnt=0 for %0d cycles, required gnt=1", p, a, wc);
      end else begin
         checks++;
         if (ram_en !== !oor || ram_we !== (w & !oor) || (!oor && ram_addr !== a[8:0])) begin
            errors++;
            $display("FAIL ram_ctrl port %0d addr %h: en=%b we=%b addr=%h, required en=%b we=%b addr=%h",
                     p, a, ram_en, ram_we, ram_addr, !oor, w & !oor, a[8:0]);
         end
         if (expect_rsp) push_exp(p, w, a, d);
         else if (w && !oor) exp_mem[a[8:0]] = d;
      end
      waited = wc;
      @(posedge clk_p); #1;
      drive(p, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic reset_pulse();
      repeat (3) begin @(posedge clk_p); #1; end
      RESET_N = 1'b0;
      @(posedge clk_p); #1;
      RESET_N = 1'b1;
   endtask

   task automatic test_reset();
      drive(0, 1'b1, 1'b0, 31'h5, '0);
      drive(1, 1'b1, 1'b1, 31'h6, 32'h1);
      repeat (2) @(negedge clk_p);
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_en, ram_we} !== 8'h00 ||
          rdata0 !== 32'h0 || rdata1 !== 32'h0 || grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b%b rv=%b%b err=%b%b en=%b we=%b rd0=%h rd1=%h cnt=%h/%h, required all 0",
                  gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_en, ram_we, rdata0, rdata1, grant_cnt0, grant_cnt1);
      end
      @(posedge clk_p); #1;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      RESET_N = 1'b1;
   endtask

   task automatic test_read_basic();
      int w;
      issue(0, 1'b0, 31'h005, '0, 1, w);
      issue(1, 1'b0, 31'h010, '0, 1, w);
   endtask

   task automatic test_round_robin();
      int   order[8] = '{0, 1, 0, 1, 1, 0, 0, 1};
      logic both[8]  = '{1, 1, 1, 1, 0, 1, 1, 1};
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         int win;
         drive(0, 1'b1, 1'b0, 31'h00A, '0);
         drive(1, both[i] ? 1'b1 : 1'b1, 1'b0, 31'h014, '0);
         if (!both[i]) drive(0, 1'b0, 1'b0, '0, '0);
         if (i == 6) drive(1, 1'b0, 1'b0, '0, '0);
         if (i == 6) drive(0, 1'b1, 1'b0, 31'h00A, '0);
         @(negedge clk_p);
         win = order[i];
         checks++;
         if ({gnt1, gnt0} !== ((win == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL rr_order step %0d: gnt1gnt0=%b%b, required winner port %0d", i, gnt1, gnt0, win);
         end else push_exp(win, 1'b0, (win == 0) ? 31'h00A : 31'h014, '0);
         @(posedge clk_p); #1;
         if (i == 4 || i == 6) begin
            drive(0, 1'b0, 1'b0, '0, '0);
            drive(1, 1'b0, 1'b0, '0, '0);
            repeat (2) begin @(posedge clk_p); #1; end
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_write_read();
      int w;
      issue(1, 1'b1, 31'h1FF, 32'h12345678, 1, w);
      issue(1, 1'b0, 31'h1FF, '0, 1, w);
      issue(1, 1'b0, 31'h000, '0, 1, w);
   endtask

   task automatic test_out_of_range();
      int w;
      issue(0, 1'b0, 31'h200, '0, 1, w);
      issue(0, 1'b1, 31'h205, 32'h0BAD0BAD, 1, w);
      issue(1, 1'b1, 31'h40000005, 32'h0BADF00D, 1, w);
      issue(0, 1'b0, 31'h005, '0, 1, w);
   endtask

   task automatic test_back_to_back();
      int w;
      for (int i = 0; i < 6; i++) begin
         issue(i % 2, 1'b0, 31'(i + 32), '0, 1, w);
         checks++;
         if (w != 0) begin
            errors++;
            $display("FAIL back_to_back %0d: waited %0d cycles, required 0", i, w);
         end
      end
   endtask

   task automatic test_reset_pending();
      int w;
      repeat (2) begin @(posedge clk_p); #1; end
      issue(0, 1'b0, 31'h005, '0, 0, w);
      RESET_N = 1'b0;
      @(negedge clk_p);
      checks++;
      if (rvalid0 !== 1'b0) begin
         errors++;
         $display("FAIL pending_discard: rvalid0=%b during reset, required 0", rvalid0);
      end
      @(posedge clk_p); #1;
      RESET_N = 1'b1;
      issue(0, 1'b0, 31'h007, '0, 1, w);
      checks++;
      if (w != 0) begin
         errors++;
         $display("FAIL first_grant_after_reset: waited %0d cycles, required 0", w);
      end
   endtask

   task automatic test_stats();
      int         miss;
      logic [15:0] exp_cnt;
      miss = 0;
      reset_pulse();
      drive(1, 1'b1, 1'b0, 31'h200, '0);
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk_p);
         if (gnt1 !== 1'b1 || gnt0 !== 1'b0) miss++;
         else push_exp(1, 1'b0, 31'h200, '0);
         if (i == 100 || i == 65534) begin
`ifdef JTAG_RAM_ARBITER_STATS_EN
            exp_cnt = 16'(i);
`else
            exp_cnt = 16'h0;
`endif
            checks++;
            if (grant_cnt1 !== exp_cnt || grant_cnt0 !== 16'h0) begin
               errors++;
               $display("FAIL grant_cnt after %0d grants: cnt1=%h cnt0=%h, required %h/0000", i, grant_cnt1, grant_cnt0, exp_cnt);
            end
         end
      end
      @(posedge clk_p); #1;
      drive(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk_p);
      checks++;
      if (miss != 0) begin
         errors++;
         $display("FAIL stats_grants: %0d cycles without gnt1, required 0", miss);
      end
`ifdef JTAG_RAM_ARBITER_STATS_EN
      exp_cnt = 16'hFFFF;
`else
      exp_cnt = 16'h0;
`endif
      checks++;
      if (grant_cnt1 !== exp_cnt) begin
         errors++;
         $display("FAIL grant_cnt_saturate: cnt1=%h, required %h", grant_cnt1, exp_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i]     = 32'hA5000000 | 32'(i);
         exp_mem[i] = 32'hA5000000 | 32'(i);
      end
      mem[5]     = 32'hDEADBEEF;
      exp_mem[5] = 32'hDEADBEEF;
      @(posedge clk_p); #1;
      test_reset();
      test_read_basic();
      test_round_robin();
      test_write_read();
      test_out_of_range();
      test_back_to_back();
      test_reset_pending();
      test_stats();
      repeat (3) begin @(posedge clk_p); #1; end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtag_ram_arbiter.md
JTAG_RAM_ARBITER -- requirements
Module: jtag_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, RAM word-address width (512 x 32 block RAM).
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk_p  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port RESET_N  input  1  asynchronous active-low reset.
REQ-006 Ports reqN  input  1  access request from requester N (N=0 JTAG side, N=1 local side).
REQ-007 Ports weN  input  1  request is a write (1) or a read (0).
REQ-008 Ports addrN  input  31  word address; bits above ADDR_W-1 select out-of-range.
REQ-009 Ports wdataN  input  DATA_W  write data.
REQ-010 Ports gntN  output  1  request accepted this cycle.
REQ-011 Ports rvalidN  output  1  response for requester N this cycle.
REQ-012 Ports rdataN  output  DATA_W  read data; valid while rvalidN=1.
REQ-013 Ports errN  output  1  out-of-range response; valid while rvalidN=1.
REQ-014 Port ram_en  output  1  RAM enable.
REQ-015 Port ram_we  output  1  RAM write enable.
REQ-016 Port ram_addr  output  ADDR_W  RAM address.
REQ-017 Port ram_wdata  output  DATA_W  RAM write data.
REQ-018 Port ram_rdata  input  DATA_W  RAM read data, one cycle after an enabled read.
REQ-019 Ports grant_cntN  output  16  per-requester grant count (see Configuration).

Function
REQ-020 A requester SHALL hold reqN, weN, addrN and wdataN stable from assertion until it samples gntN=1, then deassert or present the next request.
REQ-021 gntN SHALL be combinational and is asserted in the cycle the request is accepted; at most one gntN is high per cycle.
REQ-022 One request SHALL be accepted per cycle; back-to-back acceptance is allowed with no bubble.
REQ-023 Arbitration SHALL be round-robin: if only one reqN is high, it wins; if both are high, the requester not granted last wins; the last-winner pointer updates only on a grant.
REQ-024 Worst-case wait for a continuously requesting port SHALL be one grant to the other port.
REQ-025 In an in-range grant cycle, ram_en=1 and ram_we/ram_addr/ram_wdata SHALL be the winner's weN/addrN[ADDR_W-1:0]/wdataN; otherwise ram_en=0 and ram_we=0.
REQ-026 Out-of-range (any of addrN[30:ADDR_W] set): gntN SHALL still assert, ram_en stays 0, the RAM is not written.
REQ-027 rvalidN SHALL pulse for exactly one cycle, one cycle after gntN, for reads and writes alike (fixed latency 1).
REQ-028 In a read response cycle, rdataN SHALL equal ram_rdata; for writes and for out-of-range accesses rdataN SHALL be 0.
REQ-029 errN SHALL be 1 only in the rvalidN cycle of an out-of-range access.
REQ-030 rdata/err of the port not responding SHALL be 0.

Reset
REQ-031 While RESET_N=0: all gntN, rvalidN, errN, ram_en and ram_we SHALL be 0; rdataN SHALL be 0; the pointer SHALL favour port 0; grant_cntN SHALL be 0.
REQ-032 A response pending when reset asserts SHALL be discarded; no rvalid pulse follows reset release.
REQ-033 The first grant SHALL be possible in the first clk_p cycle after RESET_N deasserts.

Configuration
REQ-034 Macro JTAG_RAM_ARBITER_STATS_EN defined: grant_cntN SHALL increment on each gntN and saturate at 16'hFFFF.
REQ-035 Macro undefined: the grant_cntN ports SHALL remain present and tied to 0, with no counter flops.

Structure
REQ-036 Package jtag_ram_pkg SHALL hold the ADDR_W/DATA_W defaults, the 31-bit request address width and the requester-index constants (REQ_JTAG=0, REQ_LOCAL=1).
REQ-037 The 2-way round-robin pick SHALL be a sub-module jtag_ram_rr2 (inputs req[1:0] and last winner; outputs one-hot grant).

Verification
REQ-038 req0 read addr 0x005, RAM word 5=0xDEADBEEF -> gnt0 in cycle T, rvalid0=1 with rdata0=0xDEADBEEF at T+1, err0=0.
REQ-039 req0 and req1 held together for 4 grants after reset -> grant order 0,1,0,1.
REQ-040 req1 write addr 0x1FF, data 0x12345678 then read 0x1FF -> read returns 0x12345678; address wrap check: 0x000 unchanged.
REQ-041 req0 read addr 0x200 -> gnt0=1, ram_en=0, rvalid0=1 with err0=1 and rdata0=0 next cycle.
REQ-042 RESET_N pulsed low in the cycle after gnt0 -> no rvalid0 pulse; first request after release is granted immediately.
REQ-043 STATS_EN build, 70000 grants on port 1 -> grant_cnt1=16'hFFFF; non-STATS build -> grant_cnt1=0 throughout.
